// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_PARITY  = 2'd0;
  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  // Odd parity: data ones plus the parity bit must be odd.
  function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer followed by a glitch filter; the level only moves after
// FILTER_LEN consecutive samples disagree with it. Everything idles high.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync0, sync1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync0 <= line;
      sync1 <= sync0;
      if (sync1 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 host receiver: filters the pads, deframes 11-bit frames into a
// one-entry valid/ready buffer and holds the bus clock low while it is full.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err,
  output logic [1:0] rx_err_code,
  output logic       clk_inhibit
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_f, data_f, clk_f_d, fall;
  state_t        state, state_next;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] timer;
  logic          timeout;
  logic          start, shift, cap_par, load, err_fire;
  logic [1:0]    err_next;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (ps2_clk_in),
    .level (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .line  (ps2_data_in),
    .level (data_f)
  );

  assign fall    = clk_f_d & ~clk_f;
  assign timeout = (state != IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_f) state_next = DATA;
        DATA:    if (bit_cnt == 3'(DATA_BITS - 1)) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Stop-bit checks are prioritised framing, then parity, then overrun.
  always_comb begin
    start    = (state == IDLE) && fall && !data_f;
    shift    = (state == DATA) && fall;
    cap_par  = (state == PARITY) && fall;
    load     = 1'b0;
    err_fire = 1'b0;
    err_next = ERR_PARITY;
    if (timeout) begin
      err_fire = 1'b1;
      err_next = ERR_TIMEOUT;
    end else if ((state == STOP) && fall) begin
      if (!data_f) begin
        err_fire = 1'b1;
        err_next = ERR_FRAME;
      end else if (!parity_ok(shreg, par_bit)) begin
        err_fire = 1'b1;
        err_next = ERR_PARITY;
      end else if (rx_valid) begin
        err_fire = 1'b1;
        err_next = ERR_OVERRUN;
      end else begin
        load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_f_d     <= 1'b1;
      timer       <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_err_code <= '0;
      clk_inhibit <= 1'b0;
    end else begin
      clk_f_d <= clk_f;
      if (fall || timeout || (state == IDLE)) timer <= '0;
      else                                    timer <= timer + 1'b1;
      if (start) bit_cnt <= '0;
      if (shift) begin
        shreg   <= {data_f, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (cap_par) par_bit <= data_f;
      rx_err <= err_fire;
      if (err_fire) rx_err_code <= err_next;
      if (load) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // Drives the ps2_clk tri-state enable at the pad (data input tied 0).
      clk_inhibit <= rx_valid;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: frame-level model with byte/error scoreboards plus literal checks.
module tb_ps2_rx;

  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_data_in = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [1:0] rx_err_code;
  logic       clk_inhibit;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_err      (rx_err),
    .rx_err_code (rx_err_code),
    .clk_inhibit (clk_inhibit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: frame outcome derived from the frame rules alone.
  logic [7:0] load_q[$];
  logic [1:0] err_q[$];
  bit         model_full = 1'b0;
  logic [7:0] exp_buf = 8'h00;

  // Observations gathered by the compare process.
  int         valid_cycles = 0, inhib_cycles = 0, err_pulses = 0;
  logic [7:0] last_load = 8'h00;
  logic [1:0] last_err = 2'd0;
  logic       prev_valid = 1'b0;
  logic       rs;

  always begin
    @(posedge clk);
    rs = rst_n;
    #1;
    if (rs) begin
      check("inhibit_follows_valid", clk_inhibit, prev_valid);
      if (rx_valid && !prev_valid) begin
        if (load_q.size() == 0) begin
          check("unexpected_load", 1, 0);
        end else begin
          exp_buf = load_q.pop_front();
          check("load_byte", rx_data, exp_buf);
        end
        last_load = rx_data;
      end
      if (rx_valid) check("buffer_hold", rx_data, exp_buf);
      if (rx_err) begin
        if (err_q.size() == 0) check("unexpected_err", 1, 0);
        else                   check("err_code", rx_err_code, err_q.pop_front());
        err_pulses++;
        last_err = rx_err_code;
      end
      if (rx_valid)    valid_cycles++;
      if (clk_inhibit) inhib_cycles++;
    end
    prev_valid = rx_valid;
  end

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data_in = b;
    if (glitch) begin
      repeat (12) @(negedge clk);
      ps2_clk_in = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk_in = 1'b1;
      repeat (HALF - 15) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk_in = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop, input bit glitch);
    logic par;
    par = ~(^d) ^ bad_par;
    if (!stop)           err_q.push_back(2'd1);
    else if (bad_par)    err_q.push_back(2'd0);
    else if (model_full) err_q.push_back(2'd3);
    else begin
      load_q.push_back(d);
      model_full = !rx_ready;
    end
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit(par, glitch);
    send_bit(stop, glitch);
    ps2_data_in = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  int v0, i0, e0;

  task automatic snap();
    v0 = valid_cycles; i0 = inhib_cycles; e0 = err_pulses;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_rx_err", rx_err, 1'b0);
    check("reset_rx_err_code", rx_err_code, 2'd0);
    check("reset_clk_inhibit", clk_inhibit, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    snap();
    send_frame(8'h1C, 0, 1'b1, 0);
    check("good_1c_data", last_load, 8'h1C);
    check("good_1c_valid_cycles", valid_cycles - v0, 1);
    check("good_1c_inhibit_cycles", inhib_cycles - i0, 1);
    check("good_1c_no_err", err_pulses - e0, 0);

    snap();
    send_frame(8'hF0, 1, 1'b1, 0);
    check("parity_err_pulses", err_pulses - e0, 1);
    check("parity_err_code", last_err, 2'd0);
    check("parity_no_valid", valid_cycles - v0, 0);

    send_frame(8'h1C, 0, 1'b0, 0);
    check("frame_err_code", last_err, 2'd1);

    // Stall the bus clock after four data bits of 0x1C.
    snap();
    err_q.push_back(2'd2);
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(i >= 2, 0);
    ps2_data_in = 1'b1;
    repeat (TO + 60) @(negedge clk);
    check("timeout_err_pulses", err_pulses - e0, 1);
    check("timeout_err_code", last_err, 2'd2);

    send_frame(8'h5A, 0, 1'b1, 0);
    check("after_timeout_5a", last_load, 8'h5A);

    rx_ready = 1'b0;
    send_frame(8'h1C, 0, 1'b1, 0);
    send_frame(8'h32, 0, 1'b1, 0);
    check("overrun_data_held", rx_data, 8'h1C);
    check("overrun_valid", rx_valid, 1'b1);
    check("overrun_inhibit", clk_inhibit, 1'b1);
    check("overrun_code", last_err, 2'd3);
    @(negedge clk);
    rx_ready = 1'b1;
    model_full = 1'b0;
    @(posedge clk); #1;
    check("handshake_valid_low", rx_valid, 1'b0);
    check("handshake_inhibit_still", clk_inhibit, 1'b1);
    @(posedge clk); #1;
    check("handshake_inhibit_low", clk_inhibit, 1'b0);
    repeat (20) @(negedge clk);

    snap();
    send_frame(8'hAA, 0, 1'b1, 1);
    check("glitch_aa_data", last_load, 8'hAA);
    check("glitch_no_err", err_pulses - e0, 0);

    snap();
    send_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(i[0], 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_rx_valid", rx_valid, 1'b0);
    check("midreset_rx_err_code", rx_err_code, 2'd0);
    check("midreset_clk_inhibit", clk_inhibit, 1'b0);
    ps2_data_in = 1'b1;
    repeat (TO + 60) @(negedge clk);
    check("midreset_no_err", err_pulses - e0, 0);

    send_frame(8'h12, 0, 1'b1, 0);
    check("after_reset_12", last_load, 8'h12);

    check("loads_drained", load_q.size(), 0);
    check("errs_drained", err_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
